// File: rtl/adsr_pkg.sv
// Shared widths and FSM state encoding for the ADSR envelope / VCA voice stage.
package adsr_pkg;

  localparam int ACC_W    = 16;
  localparam int LEVEL_W  = 8;
  localparam int SAMPLE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/env_vca.sv
// VCA: sample_out = (sample_in * (level+1)) >> 8, registered on tick.
// Latency: one tick. Backpressure: none, tick-enabled only.
module env_vca
  import adsr_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [LEVEL_W-1:0]  level,
  output logic [SAMPLE_W-1:0] sample_out
);

  // level+1 makes 255 a true unity gain and 0 a full mute
  logic [LEVEL_W:0] gain;
  assign gain = {1'b0, level} + {{LEVEL_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out <= '0;
    end else if (tick) begin
      sample_out <= SAMPLE_W'(({{(LEVEL_W + 1){1'b0}}, sample_in} *
                               {{SAMPLE_W{1'b0}}, gain}) >> LEVEL_W);
    end
  end

endmodule

// File: rtl/adsr_env.sv
// Per-voice ADSR envelope + VCA; state advances on SAMPLE_TICK only. ADSR_EXP_RELEASE_EN selects exponential release.
// Latency: level/state visible the cycle after a tick; SAMPLE_OUT lags one tick. Backpressure: none.
module adsr_env
  import adsr_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                SAMPLE_TICK,
  input  logic                GATE,
  input  logic [15:0]         ATTACK_STEP,
  input  logic [15:0]         DECAY_STEP,
  input  logic [LEVEL_W-1:0]  SUSTAIN_LEVEL,
  input  logic [15:0]         RELEASE_STEP,
  input  logic [SAMPLE_W-1:0] SAMPLE_IN,
  output logic [SAMPLE_W-1:0] SAMPLE_OUT,
  output logic [LEVEL_W-1:0]  ENV_LEVEL,
  output logic                ACTIVE
);

  env_state_t       state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             gate_prev;
  logic             active_q;

  logic             rise, fall;
  logic [ACC_W:0]   att_sum, dec_diff;
  logic [ACC_W-1:0] target;
  logic [ACC_W-1:0] rel_dec;
  logic             rel_done;

  assign rise     = GATE & ~gate_prev;
  assign fall     = ~GATE & gate_prev;
  assign att_sum  = {1'b0, acc} + {1'b0, ATTACK_STEP};
  assign dec_diff = {1'b0, acc} - {1'b0, DECAY_STEP};
  assign target   = {SUSTAIN_LEVEL, 8'h00};

`ifdef ADSR_EXP_RELEASE_EN
  // forcing bit 0 guarantees progress once the shifted value reaches zero
  assign rel_dec  = (acc >> RELEASE_STEP[3:0]) | {{(ACC_W - 1){1'b0}}, 1'b1};
  assign rel_done = (acc <= rel_dec);
`else
  assign rel_dec  = RELEASE_STEP;
  assign rel_done = (RELEASE_STEP == '0) || (acc <= RELEASE_STEP);
`endif

  // gate edges are tested before target checks so they always win
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    case (state)
      IDLE: begin
        acc_nxt = '0;
        if (rise) state_nxt = ATTACK;
      end
      ATTACK: begin
        if (fall) begin
          state_nxt = RELEASE;
        end else if (ATTACK_STEP == '0 || att_sum[ACC_W]) begin
          acc_nxt   = '1;
          state_nxt = DECAY;
        end else begin
          acc_nxt = att_sum[ACC_W-1:0];
        end
      end
      DECAY: begin
        if (fall) begin
          state_nxt = RELEASE;
        end else if (DECAY_STEP == '0 || dec_diff[ACC_W] ||
                     dec_diff[ACC_W-1:0] <= target) begin
          acc_nxt   = target;
          state_nxt = SUSTAIN;
        end else begin
          acc_nxt = dec_diff[ACC_W-1:0];
        end
      end
      SUSTAIN: begin
        if (fall) state_nxt = RELEASE;
        else      acc_nxt   = target;
      end
      RELEASE: begin
        if (rise) begin
          state_nxt = ATTACK;
        end else if (rel_done) begin
          acc_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          acc_nxt = acc - rel_dec;
        end
      end
      default: begin
        acc_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      acc       <= '0;
      gate_prev <= 1'b0;
      active_q  <= 1'b0;
    end else if (SAMPLE_TICK) begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      gate_prev <= GATE;
      active_q  <= (state_nxt != IDLE);
    end
  end

  assign ENV_LEVEL = acc[ACC_W-1:ACC_W-LEVEL_W];
  assign ACTIVE    = active_q;

  env_vca u_vca (
    .clk        (CLK),
    .rst        (RST),
    .tick       (SAMPLE_TICK),
    .sample_in  (SAMPLE_IN),
    .level      (ENV_LEVEL),
    .sample_out (SAMPLE_OUT)
  );

endmodule
